// File: rtl/tack_sequencer.sv
// tack_sequencer: MC68040/060 local-bus cycle terminator.
// Serves one bus cycle at a time. Each cycle ends in a single burst-inhibited
// termination, which can come from one of three sources: the channel's
// programmed wait states, an external ack, or the watchdog.
// Ports:
//   CLK40, RESET         bus clock, asynchronous active-high reset
//   TSn, SPACE, DELAY    transfer start, address-space decodes, per-channel wait states
//   EXT_TACK, NO_WDOG    external termination request, watchdog cancel for foreign cycles
//   TACK_OE              tristate enable shared by the four strobes
//   TACKn_O/TBIn_O/TCIn_O/TEAn_O  registered active-low strobe drive values
//   CH_ACTIVE            one-hot channel in service (bit0 = ROM_EN)
//   BUSY                 sequencer not idle
module tack_sequencer #(
  parameter int unsigned     N_CH        = 4,
  parameter int unsigned     DW          = 4,
  parameter logic [N_CH-1:0] CI_MASK     = N_CH'(4'hE),
  parameter int unsigned     WDOG_CYCLES = 125,
  parameter bit              WDOG_TEA    = 1'b0,
  parameter int unsigned     PULSE       = 1
) (
  input  logic               CLK40,
  input  logic               RESET,
  input  logic               TSn,
  input  logic [N_CH-1:0]    SPACE,
  input  logic [N_CH*DW-1:0] DELAY,
  input  logic               EXT_TACK,
  input  logic               NO_WDOG,
  output logic               TACK_OE,
  output logic               TACKn_O,
  output logic               TBIn_O,
  output logic               TCIn_O,
  output logic               TEAn_O,
  output logic [N_CH-1:0]    CH_ACTIVE,
  output logic               BUSY
);

  localparam int unsigned WW = $clog2(WDOG_CYCLES + 1);
  localparam int unsigned PW = 2;

  typedef enum logic [1:0] {IDLE, WAIT, ASSERT, NEGATE} state_t;

  state_t          state;
  logic [DW-1:0]   wait_cnt;
  logic [WW-1:0]   wdog_cnt;
  logic [PW-1:0]   pulse_cnt;

  logic [N_CH-1:0] sel_oh;
  logic [DW-1:0]   sel_dly;
  logic            has_ch, in_wait, chan_exp, ext_term, abandon, wdog_exp;
  logic            term_go, tea_term, tci_n;

  // Lowest-index SPACE bit wins; the loop runs downward so it overwrites last.
  always_comb begin
    sel_oh  = '0;
    sel_dly = '0;
    for (int i = int'(N_CH) - 1; i >= 0; i--) begin
      if (SPACE[i]) begin
        sel_oh  = N_CH'(1) << i;
        sel_dly = DELAY[i*DW +: DW];
      end
    end
  end

  // Termination arbitration: channel expiry > external ack > NO_WDOG cancel > watchdog.
  always_comb begin
    has_ch   = |CH_ACTIVE;
    in_wait  = (state == WAIT);
    chan_exp = in_wait && has_ch && (wait_cnt == '0);
    ext_term = EXT_TACK && (in_wait || ((state == IDLE) && TSn));
    abandon  = in_wait && NO_WDOG && !has_ch && !EXT_TACK;
    wdog_exp = in_wait && !abandon && (wdog_cnt == WW'(WDOG_CYCLES));
    term_go  = chan_exp || ext_term || wdog_exp;
    tea_term = WDOG_TEA && wdog_exp && !chan_exp && !ext_term;
    // Only a channel expiry follows the per-channel cache policy; others always inhibit.
    tci_n    = chan_exp ? ~|(CH_ACTIVE & CI_MASK) : 1'b0;
  end

  // Sequencer state, counters and registered strobes.
  always_ff @(posedge CLK40 or posedge RESET) begin
    if (RESET) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      wdog_cnt  <= '0;
      pulse_cnt <= '0;
      TACK_OE   <= 1'b0;
      TACKn_O   <= 1'b1;
      TBIn_O    <= 1'b1;
      TCIn_O    <= 1'b1;
      TEAn_O    <= 1'b1;
      CH_ACTIVE <= '0;
      BUSY      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!TSn) begin
            state     <= WAIT;
            BUSY      <= 1'b1;
            CH_ACTIVE <= sel_oh;
            wait_cnt  <= sel_dly;
            wdog_cnt  <= '0;
          end
        end
        WAIT: begin
          if (!term_go) begin
            if (abandon) begin
              state    <= IDLE;
              BUSY     <= 1'b0;
              wdog_cnt <= '0;
            end else begin
              if (wait_cnt != '0) wait_cnt <= wait_cnt - DW'(1);
              if (wdog_cnt != WW'(WDOG_CYCLES)) wdog_cnt <= wdog_cnt + WW'(1);
            end
          end
        end
        ASSERT: begin
          if (pulse_cnt == '0) begin
            state   <= NEGATE;
            TACKn_O <= 1'b1;
            TBIn_O  <= 1'b1;
            TCIn_O  <= 1'b1;
            TEAn_O  <= 1'b1;
          end else begin
            pulse_cnt <= pulse_cnt - PW'(1);
          end
        end
        NEGATE: begin
          state     <= IDLE;
          TACK_OE   <= 1'b0;
          CH_ACTIVE <= '0;
          BUSY      <= 1'b0;
        end
        default: state <= IDLE;
      endcase

      // Entry into ASSERT, shared by the WAIT and IDLE (external ack) paths.
      if (term_go) begin
        state     <= ASSERT;
        BUSY      <= 1'b1;
        TACK_OE   <= 1'b1;
        TBIn_O    <= 1'b0;
        TACKn_O   <= tea_term;
        TEAn_O    <= ~tea_term;
        TCIn_O    <= tci_n;
        pulse_cnt <= PW'(PULSE - 1);
      end
    end
  end

endmodule

// File: tb/tb_tack_sequencer.sv
// tb_tack_sequencer: randomized scoreboard bench for tack_sequencer.
// There are two instances: one with _TACK on timeout and PULSE=1, and one with
// _TEA on timeout and PULSE=2. They share the same stimulus. For each cycle, a
// reference model predicts the termination edge and the strobe values and
// queues them per instance. Per-instance monitors pop those predictions and
// check them when the strobes appear.
module tb_tack_sequencer;

  localparam int unsigned WDOG   = 125;
  localparam logic [3:0]  CI     = 4'hE;
  localparam int          PULSE0 = 1;
  localparam int          PULSE1 = 2;
  localparam int          K_CH = 0, K_EXT = 1, K_AB = 2, K_WD = 3;
  localparam int          BIG = 1 << 30;

  logic        CLK40 = 1'b0;
  logic        RESET, TSn, EXT_TACK, NO_WDOG;
  logic [3:0]  SPACE;
  logic [15:0] DELAY;
  logic [1:0]  oe, tack_n, tbi_n, tci_n, tea_n, busy;
  logic [1:0][3:0] ch_act;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit mon_en = 1'b0;

  typedef struct {
    int         t;
    logic       tack;
    logic       tea;
    logic       tci;
    logic [3:0] ch;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  tack_sequencer #(.N_CH(4), .DW(4), .CI_MASK(CI), .WDOG_CYCLES(WDOG),
                   .WDOG_TEA(1'b0), .PULSE(PULSE0)) dut0 (
    .CLK40(CLK40), .RESET(RESET), .TSn(TSn), .SPACE(SPACE), .DELAY(DELAY),
    .EXT_TACK(EXT_TACK), .NO_WDOG(NO_WDOG), .TACK_OE(oe[0]), .TACKn_O(tack_n[0]),
    .TBIn_O(tbi_n[0]), .TCIn_O(tci_n[0]), .TEAn_O(tea_n[0]), .CH_ACTIVE(ch_act[0]),
    .BUSY(busy[0]));

  tack_sequencer #(.N_CH(4), .DW(4), .CI_MASK(CI), .WDOG_CYCLES(WDOG),
                   .WDOG_TEA(1'b1), .PULSE(PULSE1)) dut1 (
    .CLK40(CLK40), .RESET(RESET), .TSn(TSn), .SPACE(SPACE), .DELAY(DELAY),
    .EXT_TACK(EXT_TACK), .NO_WDOG(NO_WDOG), .TACK_OE(oe[1]), .TACKn_O(tack_n[1]),
    .TBIn_O(tbi_n[1]), .TCIn_O(tci_n[1]), .TEAn_O(tea_n[1]), .CH_ACTIVE(ch_act[1]),
    .BUSY(busy[1]));

  always #5 CLK40 = ~CLK40;
  always @(posedge CLK40) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d (edge %0d)", name, act, exp_v, cyc);
    end
  endtask

  function automatic logic [15:0] mkd(input int d0, input int d1, input int d2, input int d3);
    return {4'(d3), 4'(d2), 4'(d1), 4'(d0)};
  endfunction

  function automatic int low_idx(input logic [3:0] oh);
    int c = 0;
    for (int i = 0; i < 4; i++) if (oh[i]) c = i;
    return c;
  endfunction

  task automatic chk_reset_outputs(input string tag);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("%s dut%0d oe", tag, d), int'(oe[d]), 0);
      chk($sformatf("%s dut%0d strobes", tag, d),
          int'({tack_n[d], tbi_n[d], tci_n[d], tea_n[d]}), 15);
      chk($sformatf("%s dut%0d ch_active", tag, d), int'(ch_act[d]), 0);
      chk($sformatf("%s dut%0d busy", tag, d), int'(busy[d]), 0);
    end
  endtask

  // Pops the next prediction when a strobe first appears and follows it through negate and idle.
  task automatic monitor(input int d);
    exp_t r;
    int   pl, guard, qs;
    pl = (d == 0) ? PULSE0 : PULSE1;
    forever begin
      @(negedge CLK40);
      if (mon_en && oe[d] && !tbi_n[d]) begin
        qs = (d == 0) ? q0.size() : q1.size();
        if (qs == 0) begin
          checks++;
          errors++;
          $display("FAIL dut%0d unexpected_strobe: strobe seen at edge %0d, required none", d, cyc);
          guard = 0;
          while (oe[d] && guard < 200) begin
            @(negedge CLK40);
            guard++;
          end
        end else begin
          if (d == 0) r = q0.pop_front(); else r = q1.pop_front();
          chk($sformatf("dut%0d term_edge", d), cyc, r.t);
          chk($sformatf("dut%0d tack_n", d), int'(tack_n[d]), int'(r.tack));
          chk($sformatf("dut%0d tea_n", d), int'(tea_n[d]), int'(r.tea));
          chk($sformatf("dut%0d tci_n", d), int'(tci_n[d]), int'(r.tci));
          chk($sformatf("dut%0d ch_active", d), int'(ch_act[d]), int'(r.ch));
          chk($sformatf("dut%0d busy_assert", d), int'(busy[d]), 1);
          for (int p = 1; p < pl; p++) begin
            @(negedge CLK40);
            chk($sformatf("dut%0d hold_oe", d), int'(oe[d]), 1);
            chk($sformatf("dut%0d hold_tbi_n", d), int'(tbi_n[d]), 0);
            chk($sformatf("dut%0d hold_tack_n", d), int'(tack_n[d]), int'(r.tack));
            chk($sformatf("dut%0d hold_tea_n", d), int'(tea_n[d]), int'(r.tea));
          end
          @(negedge CLK40);
          chk($sformatf("dut%0d negate_oe", d), int'(oe[d]), 1);
          chk($sformatf("dut%0d negate_strobes", d),
              int'({tack_n[d], tbi_n[d], tci_n[d], tea_n[d]}), 15);
          @(negedge CLK40);
          chk($sformatf("dut%0d idle_oe", d), int'(oe[d]), 0);
          chk($sformatf("dut%0d idle_ch_active", d), int'(ch_act[d]), 0);
          chk($sformatf("dut%0d idle_busy", d), int'(busy[d]), 0);
        end
      end
    end
  endtask

  initial monitor(0);
  initial monitor(1);

  // Runs one bus cycle: ext_off/nw_off are edge offsets after TS (0 = none).
  // With idle_ext set, the external ack arrives in IDLE and there is no TS.
  task automatic run_txn(input logic [3:0] sp, input logic [15:0] dl,
                         input int ext_off, input int nw_off, input bit idle_ext);
    int         e, t, kind, c, end_e, tc, te, ta, tw;
    logic [3:0] oh;
    exp_t       r;
    @(negedge CLK40);
    e        = cyc + 1;
    SPACE    = sp;
    DELAY    = dl;
    TSn      = idle_ext;
    EXT_TACK = idle_ext;
    NO_WDOG  = 1'b0;
    oh = sp & (~sp + 4'd1);
    c  = low_idx(oh);
    if (idle_ext) begin
      t    = e;
      kind = K_EXT;
    end else begin
      tc = (oh != 4'd0) ? e + 1 + int'(dl[c*4 +: 4]) : BIG;
      te = (ext_off != 0) ? e + ext_off : BIG;
      ta = (nw_off != 0 && oh == 4'd0) ? e + nw_off : BIG;
      tw = e + 1 + int'(WDOG);
      t = tc; kind = K_CH;
      if (te < t) begin t = te; kind = K_EXT; end
      if (ta < t) begin t = ta; kind = K_AB;  end
      if (tw < t) begin t = tw; kind = K_WD;  end
    end
    if (kind != K_AB) begin
      for (int d = 0; d < 2; d++) begin
        r.t    = t;
        r.ch   = idle_ext ? 4'd0 : oh;
        r.tack = (kind == K_WD && d == 1);
        r.tea  = !(kind == K_WD && d == 1);
        r.tci  = (kind == K_CH) ? !CI[c] : 1'b0;
        if (d == 0) q0.push_back(r); else q1.push_back(r);
      end
    end
    end_e = (kind == K_AB) ? t : t + PULSE1 + 1;
    for (int o = 1; o <= end_e - e + 1; o++) begin
      @(negedge CLK40);
      TSn      = 1'b1;
      SPACE    = 4'($urandom);
      DELAY    = 16'($urandom);
      EXT_TACK = (!idle_ext && ext_off != 0 && o == ext_off);
      NO_WDOG  = (nw_off != 0 && o == nw_off);
      if (kind == K_AB && cyc == t) begin
        chk("abandon dut0 busy", int'(busy[0]), 0);
        chk("abandon dut1 busy", int'(busy[1]), 0);
        chk("abandon oe", int'(oe), 0);
      end
    end
    EXT_TACK = 1'b0;
    NO_WDOG  = 1'b0;
  endtask

  initial begin
    #900000;
    $display("FAIL global_timeout: simulation still running at %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0]  sp;
    logic [15:0] dl;
    int          ext_off, nw_off, sel, dch, e;
    bit          idle;

    RESET = 1'b1; TSn = 1'b1; SPACE = 4'd0; DELAY = 16'd0;
    EXT_TACK = 1'b0; NO_WDOG = 1'b0;
    repeat (2) @(negedge CLK40);
    chk_reset_outputs("por");
    RESET  = 1'b0;
    mon_en = 1'b1;
    repeat (2) @(negedge CLK40);

    run_txn(4'b0001, mkd(3, 9, 9, 9), 0, 0, 1'b0);   // ROM channel, 3 waits, cacheable
    run_txn(4'b0100, mkd(9, 9, 0, 9), 0, 0, 1'b0);   // zero-wait, cache-inhibited
    run_txn(4'b0000, mkd(0, 0, 0, 0), 0, 0, 1'b0);   // watchdog timeout
    run_txn(4'b0000, mkd(0, 0, 0, 0), 0, 10, 1'b0);  // NO_WDOG cancel, no strobes
    run_txn(4'b0010, mkd(9, 2, 9, 9), 3, 0, 1'b0);   // ext ack coincides with expiry
    run_txn(4'b0001, mkd(2, 9, 9, 9), 3, 0, 1'b0);   // tie on ROM: channel policy keeps _TCI high
    run_txn(4'b0001, mkd(5, 9, 9, 9), 2, 0, 1'b0);   // early ext ack on ROM inhibits cache
    run_txn(4'b1010, mkd(1, 7, 1, 4), 0, 0, 1'b0);   // lowest set bit wins
    run_txn(4'b0000, mkd(0, 0, 0, 0), 0, 0, 1'b1);   // ext ack from IDLE
    run_txn(4'b0000, mkd(0, 0, 0, 0), 126, 0, 1'b0); // ext ack on the timeout edge
    run_txn(4'b0010, mkd(9, 15, 9, 9), 0, 0, 1'b0);  // maximum delay

    for (int n = 0; n < 70; n++) begin
      sp = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 7) == 0) sp = 4'd0;
      dl = 16'($urandom);
      ext_off = 0; nw_off = 0; idle = 1'b0;
      if ($urandom_range(0, 9) == 0) begin
        idle = 1'b1;
      end else if (sp == 4'd0) begin
        sel = int'($urandom_range(0, 2));
        if (sel == 0) nw_off = int'($urandom_range(1, 126));
        else if (sel == 1) ext_off = int'($urandom_range(1, 126));
      end else begin
        dch = int'(dl[low_idx(sp & (~sp + 4'd1))*4 +: 4]);
        if ($urandom_range(0, 2) == 0) ext_off = int'($urandom_range(1, dch + 1));
        else if ($urandom_range(0, 3) == 0) nw_off = int'($urandom_range(1, dch + 1));
      end
      run_txn(sp, dl, ext_off, nw_off, idle);
      repeat ($urandom_range(0, 2)) @(negedge CLK40);
    end
    repeat (4) @(negedge CLK40);

    // Reset while _TACK is asserted must drop everything asynchronously.
    mon_en = 1'b0;
    @(negedge CLK40);
    e = cyc + 1;
    SPACE = 4'b0100; DELAY = mkd(9, 9, 0, 9); TSn = 1'b0;
    @(negedge CLK40);
    TSn = 1'b1;
    @(negedge CLK40);
    chk("pre_reset dut0 tack_n low", int'(tack_n[0]), 0);
    chk("pre_reset dut1 tack_n low", int'(tack_n[1]), 0);
    chk("pre_reset edge", cyc, e + 1);
    #2 RESET = 1'b1;
    #1 chk_reset_outputs("mid_reset");
    @(negedge CLK40);
    RESET = 1'b0;
    @(negedge CLK40);
    mon_en = 1'b1;
    run_txn(4'b0010, mkd(0, 5, 0, 0), 0, 0, 1'b0);
    repeat (6) @(negedge CLK40);

    chk("dut0 queue drained", q0.size(), 0);
    chk("dut1 queue drained", q1.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
